sync_n_fifo: RTL and testbench
==============================

Name: sync_n_fifo

Overview:
- Parametrised lock-step multi-channel FIFO for the probe engine.
- Successor to the fixed 3x64x512 vendor-core wrapper.
- N independent write channels, one shared read/pop across all channels.
- Adds first-word-fall-through output, per-channel occupancy, sticky overflow/underflow flags and a synchronous flush; storage is inferred RAM, no vendor core.

Parameters:
NUM_CH, 3, number of channels (1..8)
DATA_WIDTH, 64, bits per channel word
DEPTH, 512, words per channel; power of two, >= 4
AFULL_THRESH, DEPTH-12, per-channel almost-full asserts when occupancy >= this value
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
flush_in  in  1  synchronous flush of all channels, same effect as rst on the FIFO state
write_en_in  in  NUM_CH  per-channel push strobe
data_in  in  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
afull_out  out  NUM_CH  per-channel almost-full, registered
full_out  out  NUM_CH  per-channel full (occupancy == DEPTH), registered
valid_out  out  1  every channel holds a head word; data_out valid
read_en_in  in  1  pop head word of every channel; honoured only when valid_out=1
data_out  out  NUM_CH*DATA_WIDTH  FWFT head words, same packing as data_in
count_out  out  NUM_CH*CNT_W  per-channel occupancy, registered
overflow_out  out  NUM_CH  sticky: write attempted while channel full
underflow_out  out  1  sticky: read_en_in while valid_out=0

Behaviour:
Reset and flush:
- rst (or flush_in) at an edge clears all pointers, counts and the FWFT output stage.
- Outputs after that edge: valid_out=0, afull_out=0, full_out=0, count_out=0, data_out=0.
- rst clears overflow_out and underflow_out; flush_in does NOT clear sticky flags.
- rst/flush dominate any write or read in the same cycle; that write/read is discarded and does not set sticky flags.
- RAM contents are not cleared.

Write:
- A write on channel k is accepted at the edge iff write_en_in[k]=1 and count[k] < DEPTH (the count before this edge).
- If count[k]==DEPTH, the write is dropped and overflow_out[k] is set at that edge, even if a pop occurs in the same cycle.
- Write pointer wraps modulo DEPTH.

Read:
- A pop is accepted iff read_en_in=1 and valid_out=1; it pops all channels simultaneously.
- If read_en_in=1 and valid_out=0: no state change, underflow_out set.

Occupancy:
- count[k] counts every accepted word, including the word held in the FWFT stage.
- Next count: +1 on write-only, -1 on pop-only, unchanged on simultaneous write and pop.
- afull_out[k] = (next count >= AFULL_THRESH); full_out[k] = (next count == DEPTH).
- Both are registered, so they reflect the count visible on count_out in the same cycle.

FWFT timing:
- A word written at edge t into an empty channel is on data_out and counted toward valid_out from edge t+2 (one cycle RAM read, one cycle output register).
- valid_out = AND over channels of head-valid.
- With continuous pops and all channels backed up, throughput is one word per clock with no bubbles.
- data_out holds stable while valid_out=1 and no pop.

Ordering:
- Strict per-channel FIFO order.
- Channels are popped together, so word i of every channel leaves in the same cycle.

Test Plan:
1. Reset: assert rst 2 cycles with write_en_in=3'b111 -> count_out all 0, valid_out=0, sticky flags 0, no word stored.
2. Lock-step: write 0xA0/0xB0/0xC0 to ch0/1/2 at edge t -> valid_out=1 at t+2 with data_out={0xC0,0xB0,0xA0}; pop -> valid_out=0 next cycle, counts 0.
3. Skewed fill: write ch0 and ch1 ten words each, ch2 none -> valid_out stays 0, count_out={0,10,10}; write one word to ch2 -> valid_out=1 two edges later, head words are the first of each channel.
4. Thresholds: DEPTH=16, AFULL_THRESH=4; write ch0 only -> afull_out[0] rises the cycle count reaches 4, full_out[0] at 16; 17th write -> dropped, overflow_out[0]=1, count stays 16.
5. Streaming: fill all channels to 8, then read_en_in=1 and write_en_in=111 every cycle for 100 cycles -> counts stay 8, one pop per cycle, output sequence matches input order, exercises pointer wrap.
6. Flush and underflow: read_en_in=1 while empty -> underflow_out=1; then fill to 5 and pulse flush_in together with a write -> counts 0, valid_out=0, underflow_out still 1; rst -> underflow_out=0.

Source files
------------

// File: rtl/sync_n_fifo.sv
// sync_n_fifo: lock-step multi-channel FIFO with first-word-fall-through output.
//
// Each of NUM_CH channels has its own write strobe, storage and occupancy
// counter. Reads are shared: a pop removes the head word of every channel in
// the same cycle, so word i of every channel leaves together.
//
// Ports
//   clk            rising-edge clock for all logic
//   rst            synchronous active-high reset (clears sticky flags too)
//   flush_in       synchronous flush of all FIFO state; sticky flags are kept
//   write_en_in    per-channel push strobe
//   data_in        per-channel write data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   afull_out      per-channel almost-full (occupancy >= AFULL_THRESH), registered
//   full_out       per-channel full (occupancy == DEPTH), registered
//   valid_out      every channel holds a head word, data_out is valid
//   read_en_in     pop all channels; ignored unless valid_out=1
//   data_out       per-channel head words, same packing as data_in
//   count_out      per-channel occupancy, CNT_W bits per channel, registered
//   overflow_out   sticky per-channel: write attempted while full
//   underflow_out  sticky: read_en_in seen while valid_out=0
//
// Handshake: a write on channel k is taken at the edge when write_en_in[k]=1
// and the channel is not full; a pop is taken when read_en_in=1 and
// valid_out=1. rst/flush_in win over any write or pop in the same cycle.
//
// Per-channel datapath: RAM -> s1 (registered RAM read) -> out (FWFT head).
// A word written into an empty channel reaches the head two edges later.
module sync_n_fifo #(
    parameter int NUM_CH         = 3,
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 512,
    parameter int AFULL_THRESH   = DEPTH - 12,
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_in,
    input  logic [NUM_CH-1:0]            write_en_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]            afull_out,
    output logic [NUM_CH-1:0]            full_out,
    output logic                         valid_out,
    input  logic                         read_en_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH*CNT_W-1:0]      count_out,
    output logic [NUM_CH-1:0]            overflow_out,
    output logic                         underflow_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

    logic              clr;
    logic              pop;
    logic [NUM_CH-1:0] head_valid;
    logic              underflow_q;

    assign clr       = rst | flush_in;
    assign valid_out = &head_valid;
    assign pop       = read_en_in & valid_out & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (!flush_in && read_en_in && !valid_out) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow_out = underflow_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CNT_W-1:0]      count_q, count_d, in_pipe;
        logic                  s1_valid_q, s1_valid_d;
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic                  afull_q, full_q, ovf_q, ovf_d;
        logic                  wr_acc, fetch, adv, ram_nonempty;

        always_comb begin
            // Words still sitting in RAM = occupancy minus the ones already
            // pulled into the two pipeline registers.
            in_pipe      = CNT_W'(s1_valid_q) + CNT_W'(out_valid_q);
            ram_nonempty = count_q > in_pipe;
            wr_acc       = write_en_in[k] && (count_q != DEPTH_C) && !clr;
            // Head register can take a new word when it is empty or popped.
            adv          = pop || !out_valid_q;
            // s1 can be refilled when empty or when it moves into the head.
            fetch        = ram_nonempty && (!s1_valid_q || adv) && !clr;

            wptr_d      = wptr_q;
            rptr_d      = rptr_q;
            count_d     = count_q;
            s1_valid_d  = s1_valid_q;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            ovf_d       = ovf_q;

            if (clr) begin
                wptr_d      = '0;
                rptr_d      = '0;
                count_d     = '0;
                s1_valid_d  = 1'b0;
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end else begin
                if (wr_acc) wptr_d = wptr_q + 1'b1;
                if (fetch)  rptr_d = rptr_q + 1'b1;
                if (adv) begin
                    out_valid_d = s1_valid_q;
                    if (s1_valid_q) out_data_d = s1_data_q;
                end
                if (fetch) begin
                    s1_valid_d = 1'b1;
                end else if (adv) begin
                    s1_valid_d = 1'b0;
                end
                if (wr_acc && !pop) begin
                    count_d = count_q + 1'b1;
                end else if (!wr_acc && pop) begin
                    count_d = count_q - 1'b1;
                end
                // A pop in the same cycle does not make room for this write.
                if (write_en_in[k] && (count_q == DEPTH_C)) ovf_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                count_q     <= '0;
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                afull_q     <= 1'b0;
                full_q      <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                wptr_q      <= wptr_d;
                rptr_q      <= rptr_d;
                count_q     <= count_d;
                s1_valid_q  <= s1_valid_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
                afull_q     <= (count_d >= AFULL_C);
                full_q      <= (count_d == DEPTH_C);
                ovf_q       <= ovf_d;
            end
        end

        // Storage and its read register carry no reset so they map onto RAM.
        always_ff @(posedge clk) begin
            if (wr_acc) mem_q[wptr_q] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk) begin
            if (fetch) s1_data_q <= mem_q[rptr_q];
        end

        assign head_valid[k]                          = out_valid_q;
        assign data_out[k*DATA_WIDTH +: DATA_WIDTH]   = out_data_q;
        assign count_out[k*CNT_W +: CNT_W]            = count_q;
        assign afull_out[k]                           = afull_q;
        assign full_out[k]                            = full_q;
        assign overflow_out[k]                        = ovf_q;
    end

endmodule

// File: tb/tb_sync_n_fifo.sv
// Directed testbench for sync_n_fifo (3 channels, 8-bit words, depth 16,
// almost-full at 4). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_sync_n_fifo;

    localparam int NUM_CH = 3;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 4;
    localparam int CNT_W  = 5;
    localparam int W      = NUM_CH * DW;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush_in = 1'b0;
    logic [NUM_CH-1:0]       write_en_in = '0;
    logic [W-1:0]            data_in = '0;
    logic [NUM_CH-1:0]       afull_out;
    logic [NUM_CH-1:0]       full_out;
    logic                    valid_out;
    logic                    read_en_in = 1'b0;
    logic [W-1:0]            data_out;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic [NUM_CH-1:0]       overflow_out;
    logic                    underflow_out;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    sync_n_fifo #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .write_en_in(write_en_in), .data_in(data_in),
        .afull_out(afull_out), .full_out(full_out), .valid_out(valid_out),
        .read_en_in(read_en_in), .data_out(data_out), .count_out(count_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] we, input logic [W-1:0] d, input logic re);
        write_en_in = we;
        data_in     = d;
        read_en_in  = re;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive('0, '0, 1'b0);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] stream_word(input logic [7:0] s);
        return {~s, s + 8'd64, s};
    endfunction

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        drive(3'b111, 24'hFFEEDD, 1'b0);
        drive(3'b111, 24'hFFEEDD, 1'b0);
        checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count got=%0h exp=0", count_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
        checks++; if (overflow_out !== '0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow_out); end
        checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%0b exp=0", underflow_out); end
        checks++; if (afull_out !== '0 || full_out !== '0) begin errors++; $display("FAIL reset_afull_full got=%0b/%0b exp=0/0", afull_out, full_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", data_out); end
        rst = 1'b0;
        idle(3);
        checks++; if (count_out !== '0 || valid_out !== 1'b0) begin errors++; $display("FAIL reset_no_store got=%0h/%0b exp=0/0", count_out, valid_out); end
    endtask

    task automatic test_lockstep();
        apply_reset();
        drive(3'b111, {8'hC0, 8'hB0, 8'hA0}, 1'b0);
        checks++; if (count_out !== {5'd1, 5'd1, 5'd1}) begin errors++; $display("FAIL lock_count1 got=%0h exp=%0h", count_out, {5'd1, 5'd1, 5'd1}); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_valid_t got=%0b exp=0", valid_out); end
        idle(1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_valid_t1 got=%0b exp=0", valid_out); end
        idle(1);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lock_valid_t2 got=%0b exp=1", valid_out); end
        checks++; if (data_out !== 24'hC0B0A0) begin errors++; $display("FAIL lock_data got=%0h exp=c0b0a0", data_out); end
        idle(1);
        checks++; if (valid_out !== 1'b1 || data_out !== 24'hC0B0A0) begin errors++; $display("FAIL lock_hold got=%0b/%0h exp=1/c0b0a0", valid_out, data_out); end
        drive('0, '0, 1'b1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_pop_valid got=%0b exp=0", valid_out); end
        checks++; if (count_out !== '0) begin errors++; $display("FAIL lock_pop_count got=%0h exp=0", count_out); end
    endtask

    task automatic test_skewed();
        apply_reset();
        for (int i = 0; i < 10; i++) drive(3'b011, {8'h00, 8'(8'h40 + i), 8'(8'h20 + i)}, 1'b0);
        idle(2);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skew_valid got=%0b exp=0", valid_out); end
        checks++; if (count_out !== {5'd0, 5'd10, 5'd10}) begin errors++; $display("FAIL skew_count got=%0h exp=%0h", count_out, {5'd0, 5'd10, 5'd10}); end
        drive(3'b100, {8'h60, 16'h0000}, 1'b0);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skew_valid_t got=%0b exp=0", valid_out); end
        idle(1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skew_valid_t1 got=%0b exp=0", valid_out); end
        idle(1);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL skew_valid_t2 got=%0b exp=1", valid_out); end
        checks++; if (data_out !== 24'h604020) begin errors++; $display("FAIL skew_head got=%0h exp=604020", data_out); end
        drive('0, '0, 1'b1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skew_pop_valid got=%0b exp=0", valid_out); end
        checks++; if (count_out !== {5'd0, 5'd9, 5'd9}) begin errors++; $display("FAIL skew_pop_count got=%0h exp=%0h", count_out, {5'd0, 5'd9, 5'd9}); end
    endtask

    task automatic test_thresholds();
        logic [CNT_W-1:0] exp_cnt;
        apply_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            drive(3'b001, {16'h0000, 8'(k)}, 1'b0);
            exp_cnt = CNT_W'(k);
            checks++; if (count_out[CNT_W-1:0] !== exp_cnt) begin errors++; $display("FAIL thr_count k=%0d got=%0d exp=%0d", k, count_out[CNT_W-1:0], exp_cnt); end
            checks++; if (afull_out[0] !== (k >= AFULL)) begin errors++; $display("FAIL thr_afull k=%0d got=%0b exp=%0b", k, afull_out[0], (k >= AFULL)); end
            checks++; if (full_out[0] !== (k == DEPTH)) begin errors++; $display("FAIL thr_full k=%0d got=%0b exp=%0b", k, full_out[0], (k == DEPTH)); end
        end
        checks++; if (overflow_out !== 3'b000) begin errors++; $display("FAIL thr_no_ovf got=%0b exp=000", overflow_out); end
        drive(3'b001, {16'h0000, 8'hEE}, 1'b0);
        checks++; if (count_out[CNT_W-1:0] !== 5'd16) begin errors++; $display("FAIL thr_ovf_count got=%0d exp=16", count_out[CNT_W-1:0]); end
        checks++; if (overflow_out !== 3'b001) begin errors++; $display("FAIL thr_ovf got=%0b exp=001", overflow_out); end
        checks++; if (full_out !== 3'b001 || afull_out !== 3'b001) begin errors++; $display("FAIL thr_ovf_flags got=%0b/%0b exp=001/001", full_out, afull_out); end
        idle(2);
        checks++; if (overflow_out !== 3'b001) begin errors++; $display("FAIL thr_ovf_sticky got=%0b exp=001", overflow_out); end
    endtask

    task automatic test_streaming();
        logic [7:0]   seq;
        logic [W-1:0] exp;
        apply_reset();
        exp_q.delete();
        seq = 8'd0;
        for (int i = 0; i < 8; i++) begin
            drive(3'b111, stream_word(seq), 1'b0);
            exp_q.push_back(stream_word(seq));
            seq++;
        end
        idle(2);
        checks++; if (count_out !== {5'd8, 5'd8, 5'd8}) begin errors++; $display("FAIL stream_fill got=%0h exp=%0h", count_out, {5'd8, 5'd8, 5'd8}); end
        for (int c = 0; c < 100; c++) begin
            exp = exp_q.pop_front();
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d got=%0b exp=1", c, valid_out); end
            checks++; if (data_out !== exp) begin errors++; $display("FAIL stream_data c=%0d got=%0h exp=%0h", c, data_out, exp); end
            drive(3'b111, stream_word(seq), 1'b1);
            exp_q.push_back(stream_word(seq));
            seq++;
            checks++; if (count_out !== {5'd8, 5'd8, 5'd8}) begin errors++; $display("FAIL stream_count c=%0d got=%0h exp=%0h", c, count_out, {5'd8, 5'd8, 5'd8}); end
        end
        for (int c = 0; c < 20; c++) begin
            if (valid_out && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++; if (data_out !== exp) begin errors++; $display("FAIL drain_data c=%0d got=%0h exp=%0h", c, data_out, exp); end
                drive('0, '0, 1'b1);
            end else begin
                drive('0, '0, 1'b0);
            end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
        checks++; if (count_out !== '0 || valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0h/%0b exp=0/0", count_out, valid_out); end
    endtask

    task automatic test_flush_underflow();
        apply_reset();
        drive('0, '0, 1'b1);
        checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL uf_set got=%0b exp=1", underflow_out); end
        checks++; if (count_out !== '0 || valid_out !== 1'b0) begin errors++; $display("FAIL uf_nochange got=%0h/%0b exp=0/0", count_out, valid_out); end
        for (int i = 0; i < 5; i++) drive(3'b111, {8'(8'h70 + i), 8'(8'h50 + i), 8'(8'h30 + i)}, 1'b0);
        idle(2);
        checks++; if (count_out !== {5'd5, 5'd5, 5'd5} || afull_out !== 3'b111) begin errors++; $display("FAIL fl_fill got=%0h/%0b exp=%0h/111", count_out, afull_out, {5'd5, 5'd5, 5'd5}); end
        checks++; if (valid_out !== 1'b1 || data_out !== 24'h705030) begin errors++; $display("FAIL fl_head got=%0b/%0h exp=1/705030", valid_out, data_out); end
        flush_in = 1'b1;
        drive(3'b111, 24'hABCDEF, 1'b0);
        flush_in = 1'b0;
        checks++; if (count_out !== '0 || valid_out !== 1'b0) begin errors++; $display("FAIL fl_clear got=%0h/%0b exp=0/0", count_out, valid_out); end
        checks++; if (data_out !== '0 || afull_out !== '0) begin errors++; $display("FAIL fl_outputs got=%0h/%0b exp=0/0", data_out, afull_out); end
        checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL fl_keep_uf got=%0b exp=1", underflow_out); end
        idle(3);
        checks++; if (count_out !== '0 || valid_out !== 1'b0) begin errors++; $display("FAIL fl_write_dropped got=%0h/%0b exp=0/0", count_out, valid_out); end
        drive(3'b111, {8'h93, 8'h92, 8'h91}, 1'b0);
        idle(2);
        checks++; if (valid_out !== 1'b1 || data_out !== 24'h939291) begin errors++; $display("FAIL fl_refill got=%0b/%0h exp=1/939291", valid_out, data_out); end
        apply_reset();
        checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL rst_uf_clear got=%0b exp=0", underflow_out); end
    endtask

    initial begin
        test_reset();
        test_lockstep();
        test_skewed();
        test_thresholds();
        test_streaming();
        test_flush_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
